// File: rtl/bsram_pkg.sv
// Shared types and sizing helpers for the banked block SRAM.
// Imported by the lane and the top level.
package bsram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int num_lanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int bytes_per_lane(input int lane_width);
        return lane_width / 8;
    endfunction

endpackage

// File: rtl/bsram_lane.sv
// One physical 1R1W lane: byte-enabled write, registered read-before-write.
// Swap this module for a vendor macro of the same shape.
module bsram_lane
    import bsram_pkg::*;
#(
    parameter int LANE_WIDTH = 16,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                      clk_i,
    input  logic                      re_i,
    input  logic [ADDR_WIDTH-1:0]     raddr_i,
    input  logic                      we_i,
    input  logic [ADDR_WIDTH-1:0]     waddr_i,
    input  logic [LANE_WIDTH-1:0]     wdata_i,
    input  logic [LANE_WIDTH/8-1:0]   wbe_i,
    output logic [LANE_WIDTH-1:0]     rdata_o
);

    localparam int BYTES_PER_LANE = bytes_per_lane(LANE_WIDTH);
    localparam int DEPTH          = 1 << ADDR_WIDTH;

    logic [LANE_WIDTH-1:0] mem_q [DEPTH];
    logic [LANE_WIDTH-1:0] rdata_q;

    // Read returns the pre-write contents; the top applies any bypass.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        if (we_i) begin
            for (int b = 0; b < BYTES_PER_LANE; b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bsram_banked.sv
// Banked 1R1W block SRAM with byte enables, optional write bypass
// and a post-reset zero-fill sequencer.
module bsram_banked
    import bsram_pkg::*;
#(
    parameter int CORE       = 0,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LANE_WIDTH = 16,
    parameter int INIT_ZERO  = 1,
    parameter int BYPASS     = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      readEnable,
    input  logic [ADDR_WIDTH-1:0]     readAddress,
    output logic [DATA_WIDTH-1:0]     readData,
    output logic                      readValid,
    input  logic                      writeEnable,
    input  logic [ADDR_WIDTH-1:0]     writeAddress,
    input  logic [DATA_WIDTH-1:0]     writeData,
    input  logic [DATA_WIDTH/8-1:0]   writeByteEnable,
    output logic                      ready
);

    localparam int NUM_LANES      = num_lanes(DATA_WIDTH, LANE_WIDTH);
    localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
    localparam int BYTES_PER_LANE = bytes_per_lane(LANE_WIDTH);
    localparam int DEPTH          = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FILL_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    if ((DATA_WIDTH % LANE_WIDTH) != 0 || (LANE_WIDTH % 8) != 0 || CORE < 0) begin : g_bad_cfg
        $error("bsram_banked: illegal width configuration");
    end

    state_e                   state_q;
    logic [ADDR_WIDTH:0]      fill_q;
    logic                     valid_q;
    logic                     have_q;
    logic                     byp_q;
    logic [DATA_WIDTH-1:0]    byp_data_q;
    logic [BYTES_PER_WORD-1:0] byp_be_q;

    logic                     rd_acc;
    logic                     wr_acc;
    logic                     mem_we;
    logic [ADDR_WIDTH-1:0]    mem_waddr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [BYTES_PER_WORD-1:0] mem_wbe;
    logic [DATA_WIDTH-1:0]    lane_rdata;
    logic [DATA_WIDTH-1:0]    merged;

    assign rd_acc = readEnable  && (state_q == RUN);
    assign wr_acc = writeEnable && (state_q == RUN);

    // Fill owns the write port until the sequencer reaches RUN.
    always_comb begin
        mem_we    = wr_acc;
        mem_waddr = writeAddress;
        mem_wdata = writeData;
        mem_wbe   = writeByteEnable;
        if (state_q == INIT) begin
            mem_we    = (INIT_ZERO != 0);
            mem_waddr = fill_q[ADDR_WIDTH-1:0];
            mem_wdata = '0;
            mem_wbe   = '1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            fill_q     <= '0;
            valid_q    <= 1'b0;
            have_q     <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            byp_be_q   <= '0;
        end else begin
            unique case (state_q)
                INIT: begin
                    if (INIT_ZERO == 0 || fill_q == FILL_LAST) begin
                        state_q <= RUN;
                    end
                    if (INIT_ZERO != 0) begin
                        fill_q <= fill_q + 1'b1;
                    end
                end
                RUN: ;
                default: state_q <= INIT;
            endcase
            valid_q <= rd_acc;
            if (rd_acc) begin
                have_q     <= 1'b1;
                byp_q      <= (BYPASS != 0) && wr_acc
                              && (writeAddress == readAddress);
                byp_data_q <= writeData;
                byp_be_q   <= writeByteEnable;
            end
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        bsram_lane #(
            .LANE_WIDTH (LANE_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_lane (
            .clk_i   (clock),
            .re_i    (rd_acc),
            .raddr_i (readAddress),
            .we_i    (mem_we),
            .waddr_i (mem_waddr),
            .wdata_i (mem_wdata[k*LANE_WIDTH +: LANE_WIDTH]),
            .wbe_i   (mem_wbe[k*BYTES_PER_LANE +: BYTES_PER_LANE]),
            .rdata_o (lane_rdata[k*LANE_WIDTH +: LANE_WIDTH])
        );
    end

    always_comb begin
        merged = lane_rdata;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (byp_q && byp_be_q[b]) begin
                merged[b*8 +: 8] = byp_data_q[b*8 +: 8];
            end
        end
    end

    assign readData  = have_q ? merged : '0;
    assign readValid = valid_q;
    assign ready     = (state_q == RUN);

endmodule

// File: tb/tb_bsram_banked.sv
// Randomized bench for bsram_banked against an array reference model.
// Two instances: 32-bit zero-filled with bypass, 64-bit unfilled without.
module tb_bsram_banked;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        re_a = 0, we_a = 0, rv_a, rdy_a;
    logic [3:0]  ra_a = 0, wa_a = 0, be_a = 0;
    logic [31:0] wd_a = 0, rd_a;

    logic        re_b = 0, we_b = 0, rv_b, rdy_b;
    logic [3:0]  ra_b = 0, wa_b = 0;
    logic [7:0]  be_b = 0;
    logic [63:0] wd_b = 0, rd_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ma [16];
    logic [63:0] mb [16];
    logic [31:0] last_a = 0;
    logic [63:0] last_b = 0;

    always #5 clk = ~clk;

    bsram_banked #(
        .CORE(0), .DATA_WIDTH(32), .ADDR_WIDTH(4), .LANE_WIDTH(16),
        .INIT_ZERO(1), .BYPASS(1)
    ) u_a (
        .clock(clk), .reset(rst_n),
        .readEnable(re_a), .readAddress(ra_a),
        .readData(rd_a), .readValid(rv_a),
        .writeEnable(we_a), .writeAddress(wa_a),
        .writeData(wd_a), .writeByteEnable(be_a),
        .ready(rdy_a)
    );

    bsram_banked #(
        .CORE(1), .DATA_WIDTH(64), .ADDR_WIDTH(4), .LANE_WIDTH(16),
        .INIT_ZERO(0), .BYPASS(0)
    ) u_b (
        .clock(clk), .reset(rst_n),
        .readEnable(re_b), .readAddress(ra_b),
        .readData(rd_b), .readValid(rv_b),
        .writeEnable(we_b), .writeAddress(wa_b),
        .writeData(wd_b), .writeByteEnable(be_b),
        .ready(rdy_b)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] nw,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++)
            if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    task automatic step_a(input bit re, input int ra, input bit we,
                          input int wa, input logic [31:0] wd,
                          input logic [3:0] be);
        logic [63:0] m;
        logic [31:0] exp;
        m = merge({32'h0, ma[wa]}, {32'h0, wd}, {4'h0, be});
        exp = last_a;
        if (re) exp = (we && wa == ra) ? m[31:0] : ma[ra];
        re_a = re; ra_a = 4'(ra); we_a = we; wa_a = 4'(wa);
        wd_a = wd; be_a = be;
        @(negedge clk);
        check("a_valid", {63'h0, rv_a}, {63'h0, re});
        check("a_data", {32'h0, rd_a}, {32'h0, exp});
        last_a = exp;
        if (we) ma[wa] = m[31:0];
        re_a = 0; we_a = 0;
    endtask

    task automatic step_b(input bit re, input int ra, input bit we,
                          input int wa, input logic [63:0] wd,
                          input logic [7:0] be);
        logic [63:0] exp;
        exp = re ? mb[ra] : last_b;
        re_b = re; ra_b = 4'(ra); we_b = we; wa_b = 4'(wa);
        wd_b = wd; be_b = be;
        @(negedge clk);
        check("b_valid", {63'h0, rv_b}, {63'h0, re});
        check("b_data", rd_b, exp);
        last_b = exp;
        if (we) mb[wa] = merge(mb[wa], wd, be);
        re_b = 0; we_b = 0;
    endtask

    task automatic fill_and_check(input int dummy_ignored);
        for (int k = 1; k <= 16; k++) begin
            if (k < 16) begin
                re_a = 1; ra_a = 4'd2; we_a = 1; wa_a = 4'd2;
                wd_a = 32'hFFFF_FFFF; be_a = 4'hF;
            end else begin
                re_a = 0; we_a = 0;
            end
            @(negedge clk);
            check("a_ready_fill", {63'h0, rdy_a}, {63'h0, (k >= 16)});
            check("a_valid_fill", {63'h0, rv_a}, 64'h0);
            if (k == 1)
                check("b_ready_1cyc", {63'h0, rdy_b}, 64'h1);
        end
        re_a = 0; we_a = 0;
        for (int i = 0; i < 16; i++) ma[i] = 32'h0;
        last_a = 0;
        last_b = 0;
        if (dummy_ignored != 0) last_a = 0;
    endtask

    initial begin
        int ra, wa;
        #2;
        check("a_rst_data", {32'h0, rd_a}, 64'h0);
        check("a_rst_valid", {63'h0, rv_a}, 64'h0);
        check("a_rst_ready", {63'h0, rdy_a}, 64'h0);
        check("b_rst_ready", {63'h0, rdy_b}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        fill_and_check(0);

        for (int i = 0; i < 16; i++) step_a(1, i, 0, 0, 0, 0);
        step_a(0, 0, 0, 0, 0, 0);

        step_a(0, 0, 1, 5, 32'hDEADBEEF, 4'b1111);
        step_a(0, 0, 1, 5, 32'h11223344, 4'b0101);
        step_a(1, 5, 0, 0, 0, 0);
        check("a_merge_const", {32'h0, rd_a}, 64'hDE22BE44);
        step_a(0, 0, 0, 0, 0, 0);
        step_a(0, 0, 1, 3, 32'h12345678, 4'b1111);
        step_a(1, 3, 1, 3, 32'hCAFEF00D, 4'b1100);
        check("a_bypass_const", {32'h0, rd_a}, 64'hCAFE5678);
        step_a(1, 3, 1, 3, 32'h0, 4'b0000);

        for (int n = 0; n < 300; n++) begin
            wa = $urandom_range(0, 15);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
            step_a($urandom_range(0, 1), ra, $urandom_range(0, 1), wa,
                   $urandom, 4'($urandom));
        end

        // In-flight read killed by reset, then reset again mid-fill.
        re_a = 1; ra_a = 4'd5;
        #2 rst_n = 0;
        #1;
        check("a_midrd_valid", {63'h0, rv_a}, 64'h0);
        check("a_midrd_data", {32'h0, rd_a}, 64'h0);
        check("a_midrd_ready", {63'h0, rdy_a}, 64'h0);
        re_a = 0;
        @(negedge clk);
        check("a_rst_hold_valid", {63'h0, rv_a}, 64'h0);
        rst_n = 1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("a_partial_ready", {63'h0, rdy_a}, 64'h0);
        end
        rst_n = 0;
        #1;
        check("a_midfill_ready", {63'h0, rdy_a}, 64'h0);
        check("a_midfill_data", {32'h0, rd_a}, 64'h0);
        @(negedge clk);
        rst_n = 1;
        fill_and_check(0);
        for (int i = 0; i < 16; i++) step_a(1, i, 0, 0, 0, 0);

        for (int i = 0; i < 16; i++)
            step_b(0, 0, 1, i, {$urandom, $urandom}, 8'hFF);
        step_b(0, 0, 1, 0, 64'h0123456789ABCDEF, 8'hFF);
        step_b(0, 0, 1, 0, {8{8'hAB}}, 8'h80);
        step_b(1, 0, 0, 0, 0, 0);
        check("b_lane_const", rd_b, 64'hAB23456789ABCDEF);
        step_b(1, 3, 1, 3, {8{8'h5A}}, 8'hF0);
        step_b(1, 3, 0, 0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            wa = $urandom_range(0, 15);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
            step_b($urandom_range(0, 1), ra, $urandom_range(0, 1), wa,
                   {$urandom, $urandom}, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bsram_banked.md
Name: bsram_banked

Overview:
- Parametrised successor to the core-local block SRAM wrapper.
- Provides a 1-read/1-write synchronous memory with:
  - a configurable number of width lanes;
  - byte-granular write enables;
  - registered read data with a valid flag;
  - optional same-address write-to-read bypass;
  - a post-reset zero-fill sequencer.
- Sits between the core's instruction/data memory interface and the physical SRAM lanes. Each lane is a separately inferable or macro-replaceable sub-module.

Parameters:
- CORE, 0, core index; carried through for reporting only.
- DATA_WIDTH, 32, word width; must be a multiple of LANE_WIDTH and of 8.
- ADDR_WIDTH, 12, word address width; DEPTH = 2**ADDR_WIDTH.
- LANE_WIDTH, 16, width of one physical lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- INIT_ZERO, 1, 1 = zero-fill all words after reset; 0 = skip the fill.
- BYPASS, 1, 1 = a same-cycle same-address read returns the new write data; 0 = it returns the old data.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- readEnable  in  1  read request.
- readAddress  in  ADDR_WIDTH  read word address.
- readData  out  DATA_WIDTH  registered read data.
- readValid  out  1  readData updated this cycle from a request in the previous cycle.
- writeEnable  in  1  write request.
- writeAddress  in  ADDR_WIDTH  write word address.
- writeData  in  DATA_WIDTH  write data.
- writeByteEnable  in  DATA_WIDTH/8  per-byte write mask; bit i covers writeData[8i+7:8i].
- ready  out  1  initialisation complete; requests are accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to INIT and the fill counter goes to 0.
  - readData=0, readValid=0, ready=0.
  - Memory contents are not cleared by reset itself.
- FSM states: INIT and RUN.
  - INIT, INIT_ZERO=1: each clock writes all-zero (all bytes) to the address held in the fill counter, then increments the counter. After the edge that writes address DEPTH-1, go to RUN. ready rises exactly DEPTH cycles after reset release.
  - INIT, INIT_ZERO=0: go to RUN on the first edge after reset release, so ready=1 one cycle after release.
  - RUN: terminal until the next reset.
- While ready=0:
  - readEnable and writeEnable are ignored.
  - readValid stays 0 and readData holds.
- Read path:
  - Accepted when readEnable & ready.
  - Latency is 1 cycle: readData and readValid=1 appear after the next rising edge.
  - With no read accepted, readValid=0 and readData holds its last value.
- Write path:
  - Accepted when writeEnable & ready.
  - Only bytes with writeByteEnable=1 are updated; the other bytes keep their stored values.
  - writeByteEnable=0 with writeEnable=1 is a legal no-op.
- Same-cycle read and write to the same address:
  - BYPASS=1: readData = merged word (new bytes where enabled, old bytes elsewhere).
  - BYPASS=0: readData = old word.
  - Different addresses are fully independent.
- Lane split:
  - Lane k owns bits [(k+1)*LANE_WIDTH-1 : k*LANE_WIDTH] and the corresponding byte-enable slice.
  - All lanes share the addresses and enables.
- Reset asserted mid-fill or mid-read:
  - Outputs are forced to reset values immediately.
  - An in-flight read is dropped (no readValid).
  - The fill restarts from address 0 after release.
- Address arithmetic: the fill counter is ADDR_WIDTH+1 bits so the terminal count is detected without wrap. Read/write addresses are used unmodified; there is no wrap logic.

Decomposition:
- Shared package (bsram_pkg) holds:
  - the state encoding (INIT=1'b0, RUN=1'b1);
  - helper constants: BYTES_PER_WORD = DATA_WIDTH/8, BYTES_PER_LANE = LANE_WIDTH/8;
  - the function computing NUM_LANES.
- Sub-module bsram_lane, instantiated NUM_LANES times via generate:
  - 1R1W synchronous array of LANE_WIDTH x DEPTH;
  - byte-enabled write, registered read;
  - it is the swap point for a vendor macro.
- The top level owns the FSM, fill counter, write mux (fill vs user), bypass merge and readValid.

Test Plan:
- Reset, INIT_ZERO=1, ADDR_WIDTH=4 -> ready=0 for 16 cycles after release, ready=1 on cycle 16; a subsequent read of every address returns 0x00000000 with readValid one cycle later.
- Write 0xDEADBEEF to addr 5 with mask 4'b1111, then the next cycle write 0x11223344 with mask 4'b0101 -> a read of addr 5 returns 0xDE22BE44 after 1 cycle, readValid=1 for exactly one cycle.
- BYPASS=1: same-cycle write 0xCAFEF00D mask 4'b1100 to addr 3 (holding 0x12345678) and read addr 3 -> readData=0xCAFE5678. BYPASS=0 -> 0x12345678.
- Requests issued while ready=0 (write 0xFFFFFFFF to addr 2 during the fill) -> ignored; after ready, addr 2 reads 0 and readValid was never asserted during the fill.
- Assert reset mid-fill at counter 7 and mid-read -> readData=0, readValid=0 and ready=0 immediately; the fill restarts and ready rises 16 cycles after release.
- DATA_WIDTH=64, LANE_WIDTH=16, writeByteEnable=8'h80 on addr 0 with 0xAB.. data -> only bits [63:56] change; the other three lanes are unchanged on read-back.
